// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit sequential ALU, its host sequencer and benches.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned RSP_W  = 2 * DATA_W;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_START  = 3'd2,
    ST_HOLD_A = 3'd3,
    ST_OPB    = 3'd4,
    ST_CAP_HI = 3'd5,
    ST_RESP   = 3'd6
  } seq_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  // MUL and DIV return a second (high) result byte one cycle after finish.
  function automatic logic op_two_byte(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter with synchronous clear/enable and a terminal-count flag.
module timeout_counter #(
  parameter  int unsigned TERMINAL = 64,
  localparam int unsigned CW       = $clog2(TERMINAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc_c
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc_c = (count == CW'(TERMINAL - 1));

endmodule

// File: rtl/alu_host_sequencer.sv
// Bus-side master for the sequential ALU: accepts a command, plays the ALU load
// protocol, captures the result byte(s) and returns them on a response channel.
module alu_host_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned OPB_DELAY   = 1,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RSP_W-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              alu_rst,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_sel,
  output logic [DATA_W-1:0] alu_inbus,
  input  logic [DATA_W-1:0] alu_outbus,
  input  logic              alu_finish,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  seq_state_e state, state_d;
  alu_cmd_t   cmd_q;

  logic [DATA_W-1:0] lo_q, hi_q, lo_d, hi_d;
  logic [CNT_W-1:0]  cnt;
  logic              tc_c;
  logic              accept_c, cnt_run_c, timeout_c;

  logic              cmd_ready_d, busy_d, rsp_valid_d, rsp_err_d;
  logic              alu_rst_d, alu_start_d;
  logic [OP_W-1:0]   alu_sel_d;
  logic [DATA_W-1:0] alu_inbus_d;
  logic [RSP_W-1:0]  rsp_data_d;

  assign accept_c  = (state == ST_IDLE) && cmd_valid;
  assign cnt_run_c = state inside {ST_START, ST_HOLD_A, ST_OPB};
  // A finish arriving on the terminal cycle still wins over the abort.
  assign timeout_c = cnt_run_c && tc_c && !((state == ST_OPB) && alu_finish);

  // Counts START..OPB; also paces the X hold phase.
  timeout_counter #(
    .TERMINAL (TIMEOUT_CYC)
  ) u_timeout_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (!cnt_run_c),
    .en    (cnt_run_c),
    .count (cnt),
    .tc_c  (tc_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (accept_c) state_d = ST_CLR;
      ST_CLR:    state_d = ST_START;
      ST_START:  state_d = timeout_c ? ST_RESP : ST_HOLD_A;
      ST_HOLD_A: begin
        if (timeout_c) begin
          state_d = ST_RESP;
        end else if (cnt == CNT_W'(OPB_DELAY)) begin
          state_d = ST_OPB;
        end
      end
      ST_OPB: begin
        if (alu_finish) begin
          state_d = op_two_byte(cmd_q.op) ? ST_CAP_HI : ST_RESP;
        end else if (timeout_c) begin
          state_d = ST_RESP;
        end
      end
      ST_CAP_HI: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values for the result capture and the registered outputs, keyed on state_d.
  always_comb begin
    lo_d        = lo_q;
    hi_d        = hi_q;
    cmd_ready_d = 1'b0;
    busy_d      = 1'b1;
    alu_rst_d   = 1'b0;
    alu_start_d = 1'b0;
    alu_sel_d   = '0;
    alu_inbus_d = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;

    if (accept_c || ((state == ST_RESP) && rsp_ready)) begin
      lo_d = '0;
      hi_d = '0;
    end
    if ((state == ST_OPB) && alu_finish) begin
      lo_d = alu_outbus;
      hi_d = '0;
    end
    if (state == ST_CAP_HI) begin
      hi_d = alu_outbus;
    end

    case (state_d)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      ST_CLR: alu_rst_d = 1'b1;
      ST_START: begin
        alu_start_d = 1'b1;
        alu_sel_d   = cmd_q.op;
        alu_inbus_d = cmd_q.a;
      end
      ST_HOLD_A: begin
        alu_sel_d   = cmd_q.op;
        alu_inbus_d = cmd_q.a;
      end
      ST_OPB, ST_CAP_HI: begin
        alu_sel_d   = cmd_q.op;
        alu_inbus_d = cmd_q.b;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        if (state == ST_RESP) begin
          rsp_err_d  = rsp_err;
          rsp_data_d = rsp_data;
        end else begin
          rsp_err_d  = timeout_c;
          rsp_data_d = timeout_c ? '0 : {hi_d, lo_d};
        end
      end
      default: begin
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      alu_rst   <= 1'b0;
      alu_start <= 1'b0;
      alu_sel   <= '0;
      alu_inbus <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (accept_c) begin
        cmd_q <= {cmd_op, cmd_a, cmd_b};
      end
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      alu_rst   <= alu_rst_d;
      alu_start <= alu_start_d;
      alu_sel   <= alu_sel_d;
      alu_inbus <= alu_inbus_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_data  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Bench for alu_host_sequencer: behavioural ALU, cycle-indexed expectation model,
// per-cycle compare plus directed literal checks.
module tb_alu_host_sequencer;
  import alu_pkg::*;

  localparam int unsigned OPB_DELAY   = 1;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int D = int'(OPB_DELAY);
  localparam int T = int'(TIMEOUT_CYC);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_a = 8'h00;
  logic [7:0]  cmd_b = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        alu_rst;
  logic        alu_start;
  logic [1:0]  alu_sel;
  logic [7:0]  alu_inbus;
  logic [7:0]  alu_outbus;
  logic        alu_finish;
  logic        busy;

  always #5 clk = ~clk;

  alu_host_sequencer #(
    .OPB_DELAY   (OPB_DELAY),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_rst    (alu_rst),
    .alu_start  (alu_start),
    .alu_sel    (alu_sel),
    .alu_inbus  (alu_inbus),
    .alu_outbus (alu_outbus),
    .alu_finish (alu_finish),
    .busy       (busy)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int alu_delay = 4;
  int acc_cyc = 0;
  int rst_pulses = 0;
  int start_pulses = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Result the ALU produces for {hi,lo}; hi is not returned for ADD/SUB.
  function automatic logic [15:0] spec_result(input logic [1:0] op, input logic [7:0] a,
                                               input logic [7:0] b);
    case (op)
      OP_ADD:  return {8'h00, 8'(a + b)};
      OP_SUB:  return {8'h00, 8'(a - b)};
      OP_MUL:  return 16'(a) * 16'(b);
      default: return (b == 8'h00) ? 16'hFFFF : {8'(a % b), 8'(a / b)};
    endcase
  endfunction

  // Finish is visible in cycle 3+F after accept; the last timeout-counted cycle is T+1.
  function automatic bit resp_err_for(input int f);
    return !(f >= 0 && 3 + f <= T + 1);
  endfunction

  function automatic int resp_n(input int f, input logic [1:0] op);
    if (resp_err_for(f)) return T + 2;
    return 3 + f + (op[1] ? 2 : 1);
  endfunction

  // Sequencer model: one command in flight, outputs derived from cycle index n after accept.
  bit         m_busy = 1'b0;
  int         m_t0 = 0;
  int         m_f = 0;
  logic [1:0] m_op = 2'b00;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        if ((cyc - m_t0) >= resp_n(m_f, m_op) && rsp_ready) m_busy = 1'b0;
      end else if (cmd_valid) begin
        m_busy = 1'b1;
        m_t0   = cyc;
        m_op   = cmd_op;
        m_a    = cmd_a;
        m_b    = cmd_b;
        m_f    = alu_delay;
      end
      cyc++;
    end
  end

  function automatic logic [31:0] exp_outputs();
    int n, nr;
    logic err, rv;
    logic [1:0] sel;
    logic [7:0] ib;
    logic [15:0] d;
    if (!m_busy) return 32'h8000_0000;
    n   = cyc - m_t0;
    nr  = resp_n(m_f, m_op);
    err = resp_err_for(m_f);
    sel = (n >= 2 && n < nr) ? m_op : 2'b00;
    if (n >= 2 && n <= 2 + D) ib = m_a;
    else if (n >= 3 + D && n < nr) ib = m_b;
    else ib = 8'h00;
    rv = (n >= nr);
    d  = (rv && !err) ? spec_result(m_op, m_a, m_b) : 16'h0000;
    return {1'b0, 1'b1, 1'(n == 1), 1'(n == 2), sel, ib, rv, 1'(rv && err), d};
  endfunction

  // Behavioural ALU: finish F edges after start; high byte follows one cycle later.
  bit         am_act = 1'b0;
  bit         am_hi_pend = 1'b0;
  int         am_k = 0;
  int         am_f = 0;
  logic [1:0] am_sel = 2'b00;
  logic [7:0] am_x = 8'h00;
  logic [7:0] am_hi = 8'h00;
  logic [15:0] am_res = 16'h0000;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      am_act     = 1'b0;
      am_hi_pend = 1'b0;
      alu_finish <= 1'b0;
      alu_outbus <= 8'h00;
    end else begin
      alu_finish <= 1'b0;
      if (am_hi_pend) begin
        alu_outbus <= am_hi;
        am_hi_pend = 1'b0;
      end
      if (alu_rst) begin
        am_act = 1'b0;
      end else if (alu_start) begin
        am_act = 1'b1;
        am_k   = 0;
        am_x   = alu_inbus;
        am_sel = alu_sel;
        am_f   = alu_delay;
      end else if (am_act) begin
        am_k++;
        if (am_f >= 0 && am_k == am_f) begin
          am_res = spec_result(am_sel, am_x, alu_inbus);
          alu_finish <= 1'b1;
          alu_outbus <= am_res[7:0];
          am_hi      = am_sel[1] ? am_res[15:8] : 8'hA5;
          am_hi_pend = 1'b1;
          am_act     = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle outputs", {cmd_ready, busy, alu_rst, alu_start, alu_sel, alu_inbus,
                              rsp_valid, rsp_err, rsp_data}, exp_outputs());
      if (alu_rst) rst_pulses++;
      if (alu_start) start_pulses++;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      check("cmd accept wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic get_rsp(input string name, input logic [15:0] exp_d, input logic exp_e,
                         input int hold, output int n_first);
    int w = 0;
    n_first = -1;
    while (!rsp_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!rsp_valid) begin
      check({name, " rsp wait"}, 32'(rsp_valid), 32'd1);
      return;
    end
    n_first = cyc - acc_cyc + 1;
    repeat (hold) @(negedge clk);
    check({name, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
    check({name, " rsp_err"}, 32'(rsp_err), 32'(exp_e));
    check({name, " cmd_ready in resp"}, 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({name, " rsp cleared"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset state", {cmd_ready, busy, alu_rst, alu_start, alu_sel, alu_inbus,
                          rsp_valid, rsp_err, rsp_data}, 32'h8000_0000);
    cmp_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    alu_delay = 4;
    rst_pulses = 0;
    start_pulses = 0;
    send_cmd(OP_ADD, 8'd40, 8'd12);
    get_rsp("add", 16'h0034, 1'b0, 0, n);
    check("add latency", 32'(n - 1), 32'd7);
    check("add alu_rst pulses", 32'(rst_pulses), 32'd1);
    check("add alu_start pulses", 32'(start_pulses), 32'd1);

    send_cmd(OP_SUB, 8'd40, 8'd12);
    get_rsp("sub", 16'h001C, 1'b0, 0, n);

    send_cmd(OP_MUL, 8'd200, 8'd3);
    get_rsp("mul", 16'h0258, 1'b0, 0, n);
    check("mul rsp cycle", 32'(n), 32'd9);

    alu_delay = -1;
    send_cmd(OP_ADD, 8'd1, 8'd2);
    get_rsp("timeout", 16'h0000, 1'b1, 0, n);
    check("timeout start-to-rsp", 32'(n - 2), 32'd64);

    alu_delay = 62;
    send_cmd(OP_MUL, 8'd16, 8'd16);
    get_rsp("finish on terminal", 16'h0100, 1'b0, 0, n);
    check("terminal rsp cycle", 32'(n), 32'd67);

    alu_delay = 63;
    send_cmd(OP_SUB, 8'd9, 8'd3);
    get_rsp("finish too late", 16'h0000, 1'b1, 0, n);

    alu_delay = 4;
    send_cmd(OP_DIV, 8'd100, 8'd7);
    cmd_valid = 1'b1;
    cmd_op = OP_ADD;
    cmd_a = 8'd7;
    cmd_b = 8'd9;
    get_rsp("div held", 16'h020E, 1'b0, 5, n);
    check("pending cmd ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    get_rsp("pending add", 16'h0010, 1'b0, 0, n);

    send_cmd(OP_MUL, 8'd5, 8'd6);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", {cmd_ready, busy, alu_rst, alu_start, alu_sel, alu_inbus,
                                  rsp_valid, rsp_err, rsp_data}, 32'h8000_0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_cmd(OP_ADD, 8'd40, 8'd12);
    get_rsp("after reset", 16'h0034, 1'b0, 0, n);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
